// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - receiver/CSR side signal bundle of the UART receive FIFO
interface uart_rx_fifo_if #(
  parameter int AW = 4
) ();
  logic          rx_valid_i;
  logic [7:0]    rx_data_i;
  logic          rx_frame_err_i;
  logic          rx_finish_o;
  logic          pop_i;
  logic [7:0]    rd_data_o;
  logic          rd_err_o;
  logic          empty_o;
  logic          full_o;
  logic [AW:0]   level_o;
  logic          overflow_o;
  logic          ovf_clr_i;
  logic          irq_o;

  modport master (
    output rx_valid_i, rx_data_i, rx_frame_err_i, pop_i, ovf_clr_i,
    input  rx_finish_o, rd_data_o, rd_err_o, empty_o, full_o, level_o, overflow_o, irq_o
  );

  modport slave (
    input  rx_valid_i, rx_data_i, rx_frame_err_i, pop_i, ovf_clr_i,
    output rx_finish_o, rd_data_o, rd_err_o, empty_o, full_o, level_o, overflow_o, irq_o
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive FIFO with show-ahead head and coalesced irq
// Define UART_RX_FIFO_ERR_EN to store frame-errored bytes with their flag instead of dropping them.
module uart_rx_fifo #(
  parameter int DEPTH         = 16,
  parameter int AW            = 4,
  parameter int IRQ_THRESHOLD = 2,
  parameter int TIMEOUT       = 500000
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  uart_rx_fifo_if.slave   bus
);

`ifdef UART_RX_FIFO_ERR_EN
  localparam int W = 9;
`else
  localparam int W = 8;
`endif

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [AW:0] THR_LEVEL  = (AW+1)'(IRQ_THRESHOLD);
  localparam logic [31:0] TMO_LAST   = 32'(TIMEOUT - 1);

  logic [W-1:0]  mem [DEPTH];
  logic [W-1:0]  entry;
  logic [W-1:0]  head;
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   level;
  logic [AW:0]   level_nxt;
  logic [31:0]   idle_cnt;
  logic          overflow;
  logic          rx_finish;
  logic          irq;
  logic          empty;
  logic          full;
  logic          byte_ok;
  logic          push;
  logic          pop;
  logic          ovf_set;
  logic          thr_hit;
  logic          tmo_hit;

`ifdef UART_RX_FIFO_ERR_EN
  assign byte_ok = 1'b1;
  assign entry   = {bus.rx_frame_err_i, bus.rx_data_i};
`else
  assign byte_ok = !bus.rx_frame_err_i;
  assign entry   = bus.rx_data_i;
`endif

  assign empty   = (level == '0);
  assign full    = (level == FULL_LEVEL);
  // a pop on a full FIFO frees the slot the same-cycle push lands in
  assign push    = bus.rx_valid_i && byte_ok && (!full || bus.pop_i);
  assign pop     = bus.pop_i && !empty;
  assign ovf_set = bus.rx_valid_i && byte_ok && full && !bus.pop_i;
  assign tmo_hit = !empty && (idle_cnt == TMO_LAST);

  always_comb begin
    level_nxt = level;
    if (push && !pop)
      level_nxt = level + 1'b1;
    else if (pop && !push)
      level_nxt = level - 1'b1;
  end

  assign thr_hit = (level < THR_LEVEL) && (level_nxt >= THR_LEVEL);

  always_ff @(posedge wb_clk_i) begin
    if (push)
      mem[wp] <= entry;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wp        <= '0;
      rp        <= '0;
      level     <= '0;
      idle_cnt  <= '0;
      overflow  <= 1'b0;
      rx_finish <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (push)
        wp <= wp + 1'b1;
      if (pop)
        rp <= rp + 1'b1;
      level     <= level_nxt;
      rx_finish <= push;
      irq       <= thr_hit || tmo_hit;
      // set wins over a same-cycle clear
      if (ovf_set)
        overflow <= 1'b1;
      else if (bus.ovf_clr_i)
        overflow <= 1'b0;
      if (push || pop || tmo_hit || empty)
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign head            = mem[rp];
  assign bus.rd_data_o   = empty ? 8'h00 : head[7:0];
`ifdef UART_RX_FIFO_ERR_EN
  assign bus.rd_err_o    = empty ? 1'b0 : head[8];
`else
  assign bus.rd_err_o    = 1'b0;
`endif
  assign bus.empty_o     = empty;
  assign bus.full_o      = full;
  assign bus.level_o     = level;
  assign bus.overflow_o  = overflow;
  assign bus.rx_finish_o = rx_finish;
  assign bus.irq_o       = irq;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo against a queue-based reference
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int THR   = 2;
  localparam int TMO   = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  uart_rx_fifo_if #(.AW(AW)) bus ();

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW), .IRQ_THRESHOLD(THR), .TIMEOUT(TMO)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // reference: queue of {err, byte}; timeout measured as edges since last activity
  logic [8:0] q[$];
  bit         m_ovf;
  bit         m_irq;
  bit         m_fin;
  int         cyc;
  int         last_evt;

  function automatic logic [7:0] exp_data();
    return (q.size() > 0) ? q[0][7:0] : 8'h00;
  endfunction

  function automatic logic exp_err();
`ifdef UART_RX_FIFO_ERR_EN
    return (q.size() > 0) ? q[0][8] : 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic step(input logic v, input logic [7:0] d, input logic e, input logic p, input logic c);
    int lvl;
    bit acc, pushed, popped, tmo;
    bus.rx_valid_i = v; bus.rx_data_i = d; bus.rx_frame_err_i = e;
    bus.pop_i = p; bus.ovf_clr_i = c;
    @(posedge clk);
    cyc++;
    lvl = q.size();
`ifdef UART_RX_FIFO_ERR_EN
    acc = 1'b1;
`else
    acc = !e;
`endif
    pushed = v && acc && (lvl < DEPTH || p);
    popped = p && lvl > 0;
    tmo    = lvl > 0 && (cyc - last_evt) == TMO;
    if (popped) void'(q.pop_front());
    if (pushed) q.push_back({e, d});
    if (v && acc && lvl == DEPTH && !p) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    m_irq = (lvl < THR && q.size() >= THR) || tmo;
    m_fin = pushed;
    if (pushed || popped || tmo || lvl == 0) last_evt = cyc;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int g = 0; g < 2*DEPTH && q.size() > 0; g++)
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    bus.rx_valid_i = 0; bus.rx_data_i = 0; bus.rx_frame_err_i = 0; bus.pop_i = 0; bus.ovf_clr_i = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.level_o !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", bus.level_o); end
    checks++; if (bus.empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", bus.empty_o); end
    checks++; if ({bus.full_o, bus.overflow_o, bus.irq_o, bus.rx_finish_o, bus.rd_err_o} !== 5'b0)
      begin errors++; $display("FAIL reset_flags: got %b expected 00000", {bus.full_o, bus.overflow_o, bus.irq_o, bus.rx_finish_o, bus.rd_err_o}); end
    checks++; if (bus.rd_data_o !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h expected 00", bus.rd_data_o); end
    rst = 1'b0;
    q.delete(); m_ovf = 0; m_irq = 0; m_fin = 0; cyc = 0; last_evt = 0;
    idle();
  endtask

  task automatic test_single_push();
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.rd_data_o !== 8'h55) begin errors++; $display("FAIL push_rd_data: got %h expected 55", bus.rd_data_o); end
    checks++; if (bus.level_o !== 5'd1) begin errors++; $display("FAIL push_level: got %0d expected 1", bus.level_o); end
    checks++; if (bus.rx_finish_o !== 1'b1) begin errors++; $display("FAIL push_finish: got %b expected 1", bus.rx_finish_o); end
    checks++; if (bus.irq_o !== 1'b0) begin errors++; $display("FAIL push_irq: got %b expected 0", bus.irq_o); end
    idle();
    checks++; if (bus.rx_finish_o !== 1'b0) begin errors++; $display("FAIL push_finish_len: got %b expected 0", bus.rx_finish_o); end
    drain();
  endtask

  task automatic test_threshold();
    int pulses = 0;
    step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.irq_o !== 1'b0) begin errors++; $display("FAIL thr_early: got %b expected 0", bus.irq_o); end
    step(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.irq_o !== 1'b1) begin errors++; $display("FAIL thr_pulse: got %b expected 1", bus.irq_o); end
    for (int i = 0; i < 4; i++) begin
      idle();
      if (bus.irq_o === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL thr_extra_pulses: got %0d expected 0", pulses); end
    checks++; if (bus.rd_data_o !== 8'h01) begin errors++; $display("FAIL thr_read1: got %h expected 01", bus.rd_data_o); end
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checks++; if (bus.rd_data_o !== 8'h02) begin errors++; $display("FAIL thr_read2: got %h expected 02", bus.rd_data_o); end
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checks++; if (bus.empty_o !== 1'b1) begin errors++; $display("FAIL thr_empty: got %b expected 1", bus.empty_o); end
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checks++; if (bus.level_o !== 5'd0) begin errors++; $display("FAIL underflow_level: got %0d expected 0", bus.level_o); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    checks++; if (bus.full_o !== 1'b1) begin errors++; $display("FAIL fill_full: got %b expected 1", bus.full_o); end
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", bus.overflow_o); end
    checks++; if (bus.rx_finish_o !== 1'b0) begin errors++; $display("FAIL ovf_finish: got %b expected 0", bus.rx_finish_o); end
    checks++; if (bus.level_o !== 5'd16) begin errors++; $display("FAIL ovf_level: got %0d expected 16", bus.level_o); end
    step(1'b1, 8'hAB, 1'b0, 1'b0, 1'b1);
    checks++; if (bus.overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b expected 1", bus.overflow_o); end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checks++; if (bus.overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", bus.overflow_o); end
  endtask

  task automatic test_full_push_pop();
    step(1'b1, 8'hBB, 1'b0, 1'b1, 1'b0);
    checks++; if (bus.level_o !== 5'd16) begin errors++; $display("FAIL fpp_level: got %0d expected 16", bus.level_o); end
    checks++; if (bus.rx_finish_o !== 1'b1) begin errors++; $display("FAIL fpp_finish: got %b expected 1", bus.rx_finish_o); end
    checks++; if (bus.overflow_o !== 1'b0) begin errors++; $display("FAIL fpp_ovf: got %b expected 0", bus.overflow_o); end
    for (int i = 1; i < DEPTH; i++) begin
      checks++; if (bus.rd_data_o !== 8'(i)) begin errors++; $display("FAIL fpp_read%0d: got %h expected %h", i, bus.rd_data_o, 8'(i)); end
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
    checks++; if (bus.rd_data_o !== 8'hBB) begin errors++; $display("FAIL fpp_read16: got %h expected bb", bus.rd_data_o); end
    drain();
  endtask

  task automatic test_timeout();
    int pulses = 0;
    step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 3*TMO; k++) begin
      idle();
      checks++;
      if (bus.irq_o !== ((k % TMO) == 0)) begin
        errors++; $display("FAIL timeout_irq_cycle%0d: got %b expected %b", k, bus.irq_o, (k % TMO) == 0);
      end
      if (bus.irq_o === 1'b1) pulses++;
    end
    checks++; if (pulses != 3) begin errors++; $display("FAIL timeout_count: got %0d expected 3", pulses); end
    drain();
    pulses = 0;
    for (int k = 0; k < 2*TMO; k++) begin
      idle();
      if (bus.irq_o === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL timeout_empty: got %0d expected 0", pulses); end
  endtask

  task automatic test_frame_err();
    step(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
`ifdef UART_RX_FIFO_ERR_EN
    checks++; if (bus.rd_err_o !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b expected 1", bus.rd_err_o); end
    checks++; if (bus.rd_data_o !== 8'h3C) begin errors++; $display("FAIL ferr_data: got %h expected 3c", bus.rd_data_o); end
`else
    checks++; if (bus.level_o !== 5'd0) begin errors++; $display("FAIL ferr_drop_level: got %0d expected 0", bus.level_o); end
    checks++; if (bus.rx_finish_o !== 1'b0) begin errors++; $display("FAIL ferr_drop_finish: got %b expected 0", bus.rx_finish_o); end
`endif
    drain();
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
    idle();
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.level_o !== 5'd0) begin errors++; $display("FAIL mrst_level: got %0d expected 0", bus.level_o); end
    checks++; if (bus.empty_o !== 1'b1) begin errors++; $display("FAIL mrst_empty: got %b expected 1", bus.empty_o); end
    checks++; if (bus.rd_data_o !== 8'h00) begin errors++; $display("FAIL mrst_rd_data: got %h expected 00", bus.rd_data_o); end
    @(posedge clk); cyc++;
    #1 rst = 1'b0;
    q.delete(); m_ovf = 0; m_irq = 0; m_fin = 0; last_evt = cyc;
    idle();
    checks++; if (bus.level_o !== 5'd0) begin errors++; $display("FAIL mrst_after: got %0d expected 0", bus.level_o); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      int pop_pct = (n < 300) ? 25 : 60;
      step($urandom_range(0, 99) < 55, 8'($urandom_range(0, 255)), $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < pop_pct, $urandom_range(0, 99) < 5);
      checks++;
      if (bus.level_o !== 5'(q.size()) || bus.empty_o !== (q.size() == 0) || bus.full_o !== (q.size() == DEPTH)) begin
        errors++; $display("FAIL rnd_level n=%0d: got %0d/%b/%b expected %0d", n, bus.level_o, bus.empty_o, bus.full_o, q.size());
      end
      checks++;
      if (bus.rd_data_o !== exp_data() || bus.rd_err_o !== exp_err()) begin
        errors++; $display("FAIL rnd_head n=%0d: got %h/%b expected %h/%b", n, bus.rd_data_o, bus.rd_err_o, exp_data(), exp_err());
      end
      checks++;
      if (bus.overflow_o !== m_ovf || bus.rx_finish_o !== m_fin || bus.irq_o !== m_irq) begin
        errors++; $display("FAIL rnd_flags n=%0d: got ovf=%b fin=%b irq=%b expected %b %b %b", n,
                           bus.overflow_o, bus.rx_finish_o, bus.irq_o, m_ovf, m_fin, m_irq);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_threshold();
    test_overflow();
    test_full_push_pop();
    test_timeout();
    test_frame_err();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer between the UART receiver and the Wishbone control/CSR block. Accepts each byte the receiver completes, stores it with its frame-error flag in a circular FIFO, and presents a show-ahead head entry to the CSR read path. Generates a coalesced interrupt pulse on a fill threshold or an idle timeout, so firmware drains several bytes per interrupt.

## Interface
- DEPTH, 16, entries; power of two, 4..256.
- AW, 4, log2(DEPTH).
- IRQ_THRESHOLD, 2, level at which the threshold interrupt fires; 1..DEPTH.
- TIMEOUT, 500000, idle cycles before the timeout interrupt fires; at least 1.
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- rx_valid_i  in  1  one-cycle pulse from the receiver: rx_data_i is a completed byte.
- rx_data_i  in  8  received byte.
- rx_frame_err_i  in  1  stop-bit error for the byte; qualified by rx_valid_i.
- rx_finish_o  out  1  one-cycle acknowledge to the receiver that a byte was stored.
- pop_i  in  1  CSR read of the data register; removes the head entry.
- rd_data_o  out  8  head byte (show-ahead); 0 when empty.
- rd_err_o  out  1  head entry frame-error flag; 0 when empty.
- empty_o  out  1  FIFO empty.
- full_o  out  1  FIFO full.
- level_o  out  AW+1  current entry count, 0..DEPTH.
- overflow_o  out  1  sticky: a byte was dropped because the FIFO was full.
- ovf_clr_i  in  1  clears overflow_o.
- irq_o  out  1  one-cycle interrupt pulse.

## Operation
- Storage: DEPTH entries; write pointer wp, read pointer rp, both AW bits wide and wrapping modulo DEPTH; level counter AW+1 bits. empty = (level==0), full = (level==DEPTH).
- Push: rx_valid_i && (!full || pop_i) writes mem[wp], wp+1, rx_finish_o pulses on the next cycle.
- Pop: pop_i && !empty sets rp+1. pop_i while empty is ignored; no underflow and no state change.
- Simultaneous push and pop: both take effect; level is unchanged. When full, the pop frees the slot the push uses. When empty, the push is accepted and the pop is ignored (level becomes 1).
- Overflow: rx_valid_i && full && !pop_i drops the byte, sets overflow_o, and produces no rx_finish_o. ovf_clr_i clears the flag; a set and a clear in the same cycle leave it set.
- Interrupt: irq_o pulses for one cycle when either condition below holds.
  - Threshold: level goes from below IRQ_THRESHOLD to IRQ_THRESHOLD or above.
  - Timeout: the idle counter reaches TIMEOUT-1.
- Idle counter: 32 bits. Counts only while non-empty. Clears on any accepted push or pop, when the timeout fires, and while empty.
- When both interrupt conditions hold in one cycle, irq_o gives a single pulse and the idle counter clears.
- Reset, asynchronous and usable mid-operation: wp=rp=0, level=0, idle counter 0, all outputs 0 except empty_o=1. Stored contents are discarded. The memory array itself is not reset.

## Timing
- All state updates on the rising edge of wb_clk_i.
- rd_data_o and rd_err_o are combinational reads of mem[rp], gated to 0 when empty.
- A byte pushed into an empty FIFO appears on rd_data_o one cycle after the rx_valid_i edge.
- After a pop, the next entry is presented the cycle after the pop edge.
- level_o, empty_o, full_o and overflow_o are registered and change one cycle after the causing edge.
- rx_finish_o and irq_o are registered one-cycle pulses, one cycle after the causing event.
- Back-to-back rx_valid_i pulses on consecutive cycles are each accepted while not full.

## Configuration
- UART_RX_FIFO_ERR_EN defined:
  - Entries are 9 bits: byte plus frame-error flag.
  - Bytes with a frame error are stored and flagged on rd_err_o.
- UART_RX_FIFO_ERR_EN undefined:
  - Entries are 8 bits.
  - A byte with rx_frame_err_i=1 is discarded: no write, no rx_finish_o, no overflow.
  - rd_err_o is tied to 0.

## Test plan
- Reset, then push 0x55 -> rd_data_o=0x55 one cycle later; level_o=1; rx_finish_o one pulse; irq_o stays 0 before the timeout.
- Push 0x01, then 0x02 (IRQ_THRESHOLD=2) -> exactly one irq_o pulse the cycle after the second push; pop twice -> reads 0x01 then 0x02; empty_o=1.
- Fill 16 entries, push 0xAA -> byte dropped; overflow_o=1; full_o=1; pulse ovf_clr_i together with another push -> overflow_o remains 1; ovf_clr_i alone -> overflow_o=0.
- With the FIFO full, push 0xBB and pop in the same cycle -> level_o stays 16; 0xBB is read 16th; overflow_o=0.
- One byte stored, idle for TIMEOUT cycles (TIMEOUT=20 in the bench) -> irq_o pulses once at cycle 20 and repeats every 20 cycles until popped; no pulse while empty.
- With UART_RX_FIFO_ERR_EN, push 0x3C with rx_frame_err_i=1 -> rd_err_o=1. Without the macro -> level_o stays 0. Assert wb_rst_i mid-fill -> level_o=0 and empty_o=1 immediately.
